// File: rtl/cv32e40p_alu_ft_reconfig.sv
//==============================================================================
// Module   : cv32e40p_alu_ft_reconfig
// Brief    : Votes or compares three ALU replica results. Returns per-replica
//            mismatch/check strobes to the fault-counting FSMs, keeps a sticky
//            disabled-replica mask, and degrades TMR -> DMR -> SIMPLEX -> FAIL.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cv32e40p_alu_ft_reconfig #(
    parameter int WIDTH     = 32,
    parameter int RETRY_MAX = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] res_a_i,
    input  logic [WIDTH-1:0] res_b_i,
    input  logic [WIDTH-1:0] res_c_i,
    input  logic [2:0]       perm_fault_i,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic             retry_o,
    output logic [2:0]       err_replica_o,
    output logic [2:0]       fsm_enable_o,
    output logic [2:0]       replica_en_o,
    output logic [1:0]       mode_o,
    output logic             fatal_o
);

    typedef enum logic [1:0] {
        MODE_TMR     = 2'b00,
        MODE_DMR     = 2'b01,
        MODE_SIMPLEX = 2'b10,
        MODE_FAIL    = 2'b11
    } mode_t;

    localparam logic [3:0] RETRY_LIM = RETRY_MAX[3:0];

    mode_t            mode;
    logic [2:0]       mask;
    logic [2:0]       retry_cnt;

    mode_t            mode_nxt;
    logic [2:0]       mask_nxt;
    logic [2:0]       retry_cnt_nxt;
    logic [1:0]       en_cnt_nxt;
    logic [2:0]       enabled;
    logic [3:0]       cnt_inc;
    logic             exhausted;
    logic [WIDTH-1:0] dmr_x;
    logic [WIDTH-1:0] dmr_y;
    logic [WIDTH-1:0] simplex_res;
    logic [WIDTH-1:0] result_nxt;
    logic             result_valid_nxt;
    logic             retry_nxt;
    logic [2:0]       err_nxt;
    logic [2:0]       fsm_en_nxt;
    logic [2:0]       replica_en_nxt;

    // Evaluate the current op under the registered mode and compute next state.
    always_comb begin
        enabled          = ~mask;
        mask_nxt         = mask | perm_fault_i;
        en_cnt_nxt       = {1'b0, ~mask_nxt[0]} + {1'b0, ~mask_nxt[1]}
                         + {1'b0, ~mask_nxt[2]};
        cnt_inc          = {1'b0, retry_cnt} + 4'd1;
        exhausted        = 1'b0;
        retry_cnt_nxt    = retry_cnt;
        result_nxt       = result_o;
        result_valid_nxt = 1'b0;
        retry_nxt        = 1'b0;
        err_nxt          = 3'b000;
        fsm_en_nxt       = 3'b000;

        // The two surviving replicas in DMR, the last one in SIMPLEX.
        if (mask[0]) begin
            dmr_x = res_b_i;
            dmr_y = res_c_i;
        end else if (mask[1]) begin
            dmr_x = res_a_i;
            dmr_y = res_c_i;
        end else begin
            dmr_x = res_a_i;
            dmr_y = res_b_i;
        end
        if (!mask[0])      simplex_res = res_a_i;
        else if (!mask[1]) simplex_res = res_b_i;
        else               simplex_res = res_c_i;

        if (valid_i) begin
            case (mode)
                MODE_TMR: begin
                    fsm_en_nxt = 3'b111;
                    if (res_a_i == res_b_i) begin
                        result_nxt       = res_a_i;
                        result_valid_nxt = 1'b1;
                        err_nxt[2]       = (res_c_i != res_a_i);
                    end else if (res_a_i == res_c_i) begin
                        result_nxt       = res_a_i;
                        result_valid_nxt = 1'b1;
                        err_nxt[1]       = 1'b1;
                    end else if (res_b_i == res_c_i) begin
                        result_nxt       = res_b_i;
                        result_valid_nxt = 1'b1;
                        err_nxt[0]       = 1'b1;
                    end else begin
                        retry_nxt = 1'b1;
                        err_nxt   = 3'b111;
                    end
                end
                MODE_DMR: begin
                    fsm_en_nxt = enabled;
                    if (dmr_x == dmr_y) begin
                        result_nxt       = dmr_x;
                        result_valid_nxt = 1'b1;
                        retry_cnt_nxt    = 3'd0;
                    end else begin
                        err_nxt = enabled;
                        if (cnt_inc >= RETRY_LIM) begin
                            retry_cnt_nxt = RETRY_LIM[2:0];
                            exhausted     = 1'b1;
                        end else begin
                            retry_cnt_nxt = cnt_inc[2:0];
                            retry_nxt     = 1'b1;
                        end
                    end
                end
                MODE_SIMPLEX: begin
                    result_nxt       = simplex_res;
                    result_valid_nxt = 1'b1;
                end
                default: begin
                end
            endcase
        end

        // FAIL is absorbing; otherwise the mode follows the surviving count.
        if (mode == MODE_FAIL || exhausted || en_cnt_nxt == 2'd0) begin
            mode_nxt = MODE_FAIL;
        end else if (en_cnt_nxt == 2'd3) begin
            mode_nxt = MODE_TMR;
        end else if (en_cnt_nxt == 2'd2) begin
            mode_nxt = MODE_DMR;
        end else begin
            mode_nxt = MODE_SIMPLEX;
        end

        if (mode_nxt != mode) begin
            retry_cnt_nxt = 3'd0;
        end

        replica_en_nxt = (mode_nxt == MODE_FAIL) ? 3'b000 : ~mask_nxt;
    end

    // State and registered outputs; reset is synchronous.
    always_ff @(posedge clock) begin
        if (rst) begin
            mode           <= MODE_TMR;
            mask           <= 3'b000;
            retry_cnt      <= 3'd0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            retry_o        <= 1'b0;
            err_replica_o  <= 3'b000;
            fsm_enable_o   <= 3'b000;
            replica_en_o   <= 3'b111;
            mode_o         <= MODE_TMR;
            fatal_o        <= 1'b0;
        end else begin
            mode           <= mode_nxt;
            mask           <= mask_nxt;
            retry_cnt      <= retry_cnt_nxt;
            result_o       <= result_nxt;
            result_valid_o <= result_valid_nxt;
            retry_o        <= retry_nxt;
            err_replica_o  <= err_nxt;
            fsm_enable_o   <= fsm_en_nxt;
            replica_en_o   <= replica_en_nxt;
            mode_o         <= mode_nxt;
            fatal_o        <= (mode_nxt == MODE_FAIL);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_alu_ft_reconfig.sv
//==============================================================================
// Module   : tb_cv32e40p_alu_ft_reconfig
// Brief    : Directed self-checking bench for cv32e40p_alu_ft_reconfig.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cv32e40p_alu_ft_reconfig;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] res_a_i = '0;
    logic [31:0] res_b_i = '0;
    logic [31:0] res_c_i = '0;
    logic [2:0]  perm_fault_i = '0;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        retry_o;
    logic [2:0]  err_replica_o;
    logic [2:0]  fsm_enable_o;
    logic [2:0]  replica_en_o;
    logic [1:0]  mode_o;
    logic        fatal_o;

    int n_cmp = 0;
    int n_bad = 0;

    cv32e40p_alu_ft_reconfig #(.WIDTH(32), .RETRY_MAX(2)) dut (
        .clock          (clock),
        .rst            (rst),
        .valid_i        (valid_i),
        .res_a_i        (res_a_i),
        .res_b_i        (res_b_i),
        .res_c_i        (res_c_i),
        .perm_fault_i   (perm_fault_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .retry_o        (retry_o),
        .err_replica_o  (err_replica_o),
        .fsm_enable_o   (fsm_enable_o),
        .replica_en_o   (replica_en_o),
        .mode_o         (mode_o),
        .fatal_o        (fatal_o)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one clock edge, then settle 1ns past the edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [2:0] pf);
        valid_i      = v;
        res_a_i      = a;
        res_b_i      = b;
        res_c_i      = c;
        perm_fault_i = pf;
        @(posedge clock);
        #1;
    endtask

    task automatic check_strobes(input string tag, input logic rv, input logic rt,
                                 input logic [2:0] err, input logic [2:0] fen);
        check_value({tag, ".valid"}, 32'(result_valid_o), 32'(rv));
        check_value({tag, ".retry"}, 32'(retry_o), 32'(rt));
        check_value({tag, ".err"}, 32'(err_replica_o), 32'(err));
        check_value({tag, ".fen"}, 32'(fsm_enable_o), 32'(fen));
    endtask

    task automatic check_mode(input string tag, input logic [1:0] m,
                              input logic [2:0] en, input logic fat);
        check_value({tag, ".mode"}, 32'(mode_o), 32'(m));
        check_value({tag, ".en"}, 32'(replica_en_o), 32'(en));
        check_value({tag, ".fatal"}, 32'(fatal_o), 32'(fat));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        step(1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        check_mode("rst", 2'b00, 3'b111, 1'b0);
        check_strobes("rst", 1'b0, 1'b0, 3'b000, 3'b000);
        check_value("rst.result", result_o, 32'h0);
        rst = 1'b0;

        // TMR all equal
        step(1'b1, 32'h1234, 32'h1234, 32'h1234, 3'b000);
        check_value("tmr_eq.result", result_o, 32'h1234);
        check_strobes("tmr_eq", 1'b1, 1'b0, 3'b000, 3'b111);

        // Idle holds result
        step(1'b0, 32'hdead, 32'hbeef, 32'h0, 3'b000);
        check_value("idle.result", result_o, 32'h1234);
        check_strobes("idle", 1'b0, 1'b0, 3'b000, 3'b000);

        // TMR all differ
        step(1'b1, 32'h1, 32'h2, 32'h3, 3'b000);
        check_strobes("tmr_diff", 1'b0, 1'b1, 3'b111, 3'b111);
        check_value("tmr_diff.result", result_o, 32'h1234);

        // TMR majority with B outvoted
        step(1'b1, 32'h6, 32'h8, 32'h6, 3'b000);
        check_value("tmr_b.result", result_o, 32'h6);
        check_strobes("tmr_b", 1'b1, 1'b0, 3'b010, 3'b111);

        // TMR majority with C outvoted
        step(1'b1, 32'h5, 32'h5, 32'h7, 3'b000);
        check_value("tmr_c.result", result_o, 32'h5);
        check_strobes("tmr_c", 1'b1, 1'b0, 3'b100, 3'b111);

        // Disable C -> DMR
        step(1'b0, 32'h0, 32'h0, 32'h0, 3'b100);
        check_mode("to_dmr", 2'b01, 3'b011, 1'b0);

        // DMR: mismatch, match, mismatch (counter cleared by the match)
        step(1'b1, 32'h1, 32'h2, 32'h99, 3'b000);
        check_strobes("dmr_mm1", 1'b0, 1'b1, 3'b011, 3'b011);
        step(1'b1, 32'h8, 32'h8, 32'h77, 3'b000);
        check_value("dmr_ok.result", result_o, 32'h8);
        check_strobes("dmr_ok", 1'b1, 1'b0, 3'b000, 3'b011);
        step(1'b1, 32'h1, 32'h2, 32'h0, 3'b000);
        check_strobes("dmr_mm2", 1'b0, 1'b1, 3'b011, 3'b011);
        check_mode("dmr_mm2", 2'b01, 3'b011, 1'b0);

        // Clear counter, then two consecutive mismatches -> FAIL
        step(1'b1, 32'h4, 32'h4, 32'h0, 3'b000);
        check_value("dmr_ok2.valid", 32'(result_valid_o), 32'h1);
        step(1'b1, 32'h1, 32'h2, 32'h0, 3'b000);
        check_value("dmr_f1.retry", 32'(retry_o), 32'h1);
        check_mode("dmr_f1", 2'b01, 3'b011, 1'b0);
        step(1'b1, 32'h1, 32'h2, 32'h0, 3'b000);
        check_strobes("dmr_f2", 1'b0, 1'b0, 3'b011, 3'b011);
        check_mode("dmr_f2", 2'b11, 3'b000, 1'b1);

        // FAIL is absorbing and produces nothing
        step(1'b1, 32'h3, 32'h3, 32'h3, 3'b000);
        check_strobes("fail", 1'b0, 1'b0, 3'b000, 3'b000);
        check_mode("fail", 2'b11, 3'b000, 1'b1);

        // Reset out of FAIL
        rst = 1'b1;
        step(1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        rst = 1'b0;
        check_mode("rst2", 2'b00, 3'b111, 1'b0);
        check_strobes("rst2", 1'b0, 1'b0, 3'b000, 3'b000);
        check_value("rst2.result", result_o, 32'h0);

        // Two faults in the same cycle as a TMR op
        step(1'b1, 32'h9, 32'h9, 32'h9, 3'b011);
        check_value("tmr_pf.result", result_o, 32'h9);
        check_strobes("tmr_pf", 1'b1, 1'b0, 3'b000, 3'b111);
        check_mode("tmr_pf", 2'b10, 3'b100, 1'b0);

        // SIMPLEX passes replica C; disabled replicas ignored
        step(1'b1, 32'h1, 32'h2, 32'h33, 3'b001);
        check_value("smp.result", result_o, 32'h33);
        check_strobes("smp", 1'b1, 1'b0, 3'b000, 3'b000);
        check_mode("smp", 2'b10, 3'b100, 1'b0);

        // Last replica fails -> FAIL
        step(1'b0, 32'h0, 32'h0, 32'h0, 3'b100);
        check_mode("smp_fail", 2'b11, 3'b000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
